// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial a - b, LSB first, one full-subtractor cell per clock.
// Operands enter on a valid/ready handshake; the result leaves on a valid/ready handshake.
module serial_sub_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_borrow_out;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bo;
    logic             w_last;

    // Single 1-bit full-subtractor cell fed from the operand shift registers
    assign w_d    = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
    assign w_bo   = (~r_a_sh[0] & r_borrow) | (~r_a_sh[0] & r_b_sh[0]) | (r_b_sh[0] & r_borrow);
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand load, serial shift and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_diff       <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_diff   <= {w_d, r_diff[WIDTH-1:1]};
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_borrow <= w_bo;
                    // Counter saturates at WIDTH-1 so it never wraps
                    if (w_last) begin
                        r_borrow_out <= w_bo;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE) & ~rst;
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state == S_RUN) | (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule
